// File: rtl/input_frame_buffer_pkg.sv
// rtl/input_frame_buffer_pkg.sv - shared sizes, controller timing constants and types for the input frame buffer
package input_frame_buffer_pkg;

  // Frame geometry; NUM_CH must equal 2**CH_W so wr_ptr wraps naturally
  localparam int DATA_W = 16;
  localparam int NUM_CH = 32;
  localparam int CH_W   = 5;

  // Downstream Horner-loop controller timing, used when modelling proc_done
  localparam int HORNER_ITER_DLY = 16;
  localparam int CTRL_RUN_CYCLES = 406;

  // Launch/release state of the read side
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ctrl_state_e;

  // True when a write pointer addresses the final slot of a frame
  function automatic logic is_last_slot(input logic [CH_W-1:0] ptr);
    return ptr == CH_W'(NUM_CH - 1);
  endfunction

endpackage

// File: rtl/inbuf_bank.sv
// rtl/inbuf_bank.sv - one frame bank: NUM_CH x DATA_W registers, sync write, combinational read
module inbuf_bank #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 32,
  parameter int CH_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [CH_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [CH_W-1:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [NUM_CH];

  // Store one sample per write strobe; reset clears every slot so reads return 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Unregistered read so the controller sees its channel in the same cycle
  assign rdata = mem[raddr];

endmodule

// File: rtl/input_frame_buffer.sv
// rtl/input_frame_buffer.sv - ping-pong input frame buffer feeding the Horner-loop controller (option: INBUF_DROP_ON_FULL_EN)
module input_frame_buffer #(
  parameter int DATA_W = input_frame_buffer_pkg::DATA_W,
  parameter int NUM_CH = input_frame_buffer_pkg::NUM_CH,
  parameter int CH_W   = input_frame_buffer_pkg::CH_W
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_rdy,
  output logic              srdyo,
  input  logic              proc_done,
  input  logic [CH_W-1:0]   channel_select,
  output logic [DATA_W-1:0] x_out,
  output logic [7:0]        ovf_cnt
);

  import input_frame_buffer_pkg::*;

  logic [CH_W-1:0]   wr_ptr;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        bank_full;
  ctrl_state_e       state;
  logic              busy;
  logic              wr_full;
  logic              xfer;
  logic              last_slot;
  logic              rel;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  assign busy      = (state == ST_BUSY);
  assign wr_full   = bank_full[wr_bank];
  // A full write bank never takes data, whether the source is stalled or dropped
  assign xfer      = din_valid && !wr_full;
  assign last_slot = (wr_ptr == CH_W'(NUM_CH - 1));
  assign rel       = proc_done && busy;

`ifdef INBUF_DROP_ON_FULL_EN
  logic [7:0] ovf_q;

  assign din_rdy = 1'b1;
  assign ovf_cnt = ovf_q;

  // Count samples discarded because the write bank is still awaiting the reader; saturates at 255
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      ovf_q <= 8'd0;
    end else if (din_valid && wr_full && (ovf_q != 8'hFF)) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end
`else
  assign din_rdy = !wr_full;
  assign ovf_cnt = 8'd0;
`endif

  // Advance the fill position; the last slot wraps and hands filling to the other bank
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
    end else if (xfer) begin
      if (last_slot) begin
        wr_ptr  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_ptr <= wr_ptr + CH_W'(1);
      end
    end
  end

  // Mark a bank full on its last write and empty on release; the two never target the same bank
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      bank_full <= 2'b00;
    end else begin
      if (xfer && last_slot) begin
        bank_full[wr_bank] <= 1'b1;
      end
      if (rel) begin
        bank_full[rd_bank] <= 1'b0;
      end
    end
  end

  // Read-side FSM: launch a full bank with a one-cycle srdyo, swap banks on proc_done
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state   <= ST_IDLE;
      srdyo   <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      srdyo <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bank_full[rd_bank]) begin
            srdyo <= 1'b1;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (proc_done) begin
            state   <= ST_IDLE;
            rd_bank <= ~rd_bank;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  inbuf_bank #(
    .DATA_W(DATA_W),
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W)
  ) u_bank0 (
    .clk  (clk),
    .rst  (GlobalReset),
    .we   (xfer && (wr_bank == 1'b0)),
    .waddr(wr_ptr),
    .wdata(din),
    .raddr(channel_select),
    .rdata(rdata0)
  );

  inbuf_bank #(
    .DATA_W(DATA_W),
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W)
  ) u_bank1 (
    .clk  (clk),
    .rst  (GlobalReset),
    .we   (xfer && (wr_bank == 1'b1)),
    .waddr(wr_ptr),
    .wdata(din),
    .raddr(channel_select),
    .rdata(rdata1)
  );

  // The bank owned by the reader drives x_out; it changes only with channel_select or a swap
  assign x_out = rd_bank ? rdata1 : rdata0;

endmodule

// File: tb/tb_input_frame_buffer.sv
// tb/tb_input_frame_buffer.sv - scoreboard bench for input_frame_buffer
module tb_input_frame_buffer;
  import input_frame_buffer_pkg::*;

  logic              clk = 1'b0;
  logic              GlobalReset = 1'b1;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_rdy;
  logic              srdyo;
  logic              proc_done = 1'b0;
  logic [CH_W-1:0]   channel_select = '0;
  logic [DATA_W-1:0] x_out;
  logic [7:0]        ovf_cnt;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];
  int last_edge = 0;
  int acc;
  bit ok;

  input_frame_buffer dut (
    .clk           (clk),
    .GlobalReset   (GlobalReset),
    .din           (din),
    .din_valid     (din_valid),
    .din_rdy       (din_rdy),
    .srdyo         (srdyo),
    .proc_done     (proc_done),
    .channel_select(channel_select),
    .x_out         (x_out),
    .ovf_cnt       (ovf_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every srdyo pulse must match the next expected launch cycle
  always @(negedge clk) begin
    if (!GlobalReset && srdyo) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL srdyo_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        check("srdyo_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    GlobalReset = 1'b1;
    din_valid   = 1'b0;
    proc_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1 GlobalReset = 1'b0;
  endtask

  // Offer one sample for up to budget edges; ok reports whether it transferred
  task automatic send(input logic [DATA_W-1:0] v, input int budget, output bit accepted);
    int n = 0;
    bit r = 1'b0;
    din       = v;
    din_valid = 1'b1;
    while (!r && n < budget) begin
      @(negedge clk);
      r = din_rdy;
      @(posedge clk);
      n++;
    end
    #1 din_valid = 1'b0;
    last_edge = cyc;
    accepted  = r;
  endtask

  // 32 samples base..base+31, optional idle cycle between them, expects a launch from idle
  task automatic send_frame(input int base, input bit gap);
    bit a;
    for (int k = 0; k < NUM_CH; k++) begin
      send(DATA_W'(base + k), 4, a);
      check("sample_accepted", a, 1);
      if (gap) wait_cycles(1);
    end
    exp_q.push_back(last_edge + 1);
  endtask

  task automatic pulse_done(input bit expect_launch);
    proc_done = 1'b1;
    @(posedge clk);
    #1 proc_done = 1'b0;
    if (expect_launch) exp_q.push_back(cyc + 1);
  endtask

  task automatic xcheck(input string name, input int ch, input int exp);
    channel_select = CH_W'(ch);
    @(negedge clk);
    check(name, x_out, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 GlobalReset = 1'b0;
    @(negedge clk);
    check("rst_din_rdy", din_rdy, 1);
    check("rst_srdyo", srdyo, 0);
    check("rst_x_out", x_out, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    @(posedge clk);
    #1;

    // Single back-to-back frame
    send_frame(1, 1'b0);
    wait_cycles(3);
    xcheck("single_ch5", 5, 6);
    xcheck("single_ch31", 31, 32);
    xcheck("single_ch0", 0, 1);
    do_reset();

    // 70 samples with no proc_done
    acc = 0;
    for (int k = 0; k < 70; k++) begin
      send(DATA_W'(100 + k), 3, ok);
      if (ok) acc++;
      if (k == 31) exp_q.push_back(last_edge + 1);
    end
`ifdef INBUF_DROP_ON_FULL_EN
    check("drop_accepted", acc, 70);
    @(negedge clk);
    check("drop_din_rdy", din_rdy, 1);
    check("drop_ovf_cnt", ovf_cnt, 6);
    @(posedge clk);
    #1;
    xcheck("drop_bank0_ch0", 0, 100);
    xcheck("drop_bank0_ch31", 31, 131);
    pulse_done(1'b1);
    wait_cycles(2);
    xcheck("drop_bank1_ch0", 0, 132);
    xcheck("drop_bank1_ch31", 31, 163);
`else
    check("bp_accepted", acc, 64);
    @(negedge clk);
    check("bp_din_rdy_low", din_rdy, 0);
    check("bp_ovf_cnt", ovf_cnt, 0);
    @(posedge clk);
    #1;
    xcheck("bp_bank0_ch31", 31, 131);
    pulse_done(1'b1);
    @(negedge clk);
    check("bp_din_rdy_after_done", din_rdy, 1);
    @(posedge clk);
    #1;
    wait_cycles(2);
    xcheck("bp_frame2_ch0", 0, 132);
    xcheck("bp_frame2_ch31", 31, 163);
`endif
    do_reset();

    // Gapped input
    send_frame(1, 1'b1);
    wait_cycles(3);
    xcheck("gap_ch5", 5, 6);
    xcheck("gap_ch31", 31, 32);
    xcheck("gap_ch0", 0, 1);
    do_reset();

    // Stray proc_done while idle
    pulse_done(1'b0);
    wait_cycles(3);
    xcheck("stray_idle_x_out", 0, 0);
    send_frame(200, 1'b0);
    wait_cycles(3);
    xcheck("stray_frame_a", 0, 200);
    pulse_done(1'b0);
    wait_cycles(2);
    xcheck("stray_swapped_empty", 0, 0);
    pulse_done(1'b0);
    wait_cycles(2);
    xcheck("stray_no_swap", 0, 0);
    send_frame(300, 1'b0);
    wait_cycles(3);
    xcheck("stray_frame_b", 0, 300);
    do_reset();

    // Reset in the middle of a frame
    for (int k = 0; k < 20; k++) begin
      send(DATA_W'(500 + k), 4, ok);
    end
    do_reset();
    xcheck("midrst_cleared", 0, 0);
    send_frame(600, 1'b0);
    wait_cycles(3);
    xcheck("midrst_ch0", 0, 600);
    xcheck("midrst_ch31", 31, 631);

    wait_cycles(2);
    check("final_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
